// File: rtl/net_pkt_fifo.sv
// net_pkt_fifo: frame-aware word FIFO between the MAC assembler and the DMA
// engine. Words land speculatively behind a commit pointer. A frame becomes
// readable only when its end-of-frame word arrives clean. Errored or
// overflowing frames are rewound to the last commit point and reported
// with a one-cycle frame_drop pulse.
module net_pkt_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int AFULL_TH   = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wr_eof,
  input  logic                  wr_err,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_eof,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   used,
  output logic [ADDR_WIDTH:0]   frm_cnt,
  output logic                  frame_drop
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_L = (ADDR_WIDTH+1)'(AFULL_TH);

  // Each entry carries the end-of-frame flag alongside the payload word.
  logic [DATA_WIDTH:0] mem [DEPTH];

  // Pointers are one bit wider than the address so full and empty differ.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] cm_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                ovf;

  logic wr_ok;
  logic eof_good;
  logic eof_bad;
  logic ovf_set;
  logic rd_ok;
  logic pop_eof;

  // Occupancy and status flags all derive from the registered pointers, so a
  // pop frees space for writers only on the following cycle.
  assign used        = wr_ptr - rd_ptr;
  assign full        = (used == DEPTH_L);
  assign empty       = (rd_ptr == cm_ptr);
  assign almost_full = (used >= AFULL_L);

  // First-word fall-through: the head entry is always presented.
  assign {rd_eof, rdata} = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Decode this cycle's write/read events; flush masks every one of them.
  always_comb begin
    wr_ok    = wr_en & ~full & ~ovf & ~flush;
    eof_good = wr_en & wr_eof & ~wr_err & ~ovf & ~full & ~flush;
    eof_bad  = wr_en & wr_eof & (wr_err | ovf | full) & ~flush;
    ovf_set  = wr_en & ~wr_eof & (full | ovf) & ~flush;
    rd_ok    = rd_en & ~empty & ~flush;
    pop_eof  = rd_ok & rd_eof;
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {wr_eof, wdata};
    end
  end

  // Speculative write pointer: advance, rewind to the commit point on a bad
  // frame, or collapse onto the read pointer on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
    end else if (eof_bad) begin
      wr_ptr <= cm_ptr;
    end else if (wr_ok) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Commit pointer moves past a cleanly terminated frame in one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_ptr <= '0;
    end else if (flush) begin
      cm_ptr <= rd_ptr;
    end else if (eof_good) begin
      cm_ptr <= wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on each accepted pop; flush leaves it in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (rd_ok) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Committed-frame count; a commit and an eof pop in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt <= '0;
    end else if (flush) begin
      frm_cnt <= '0;
    end else if (eof_good && !pop_eof) begin
      frm_cnt <= frm_cnt + 1'b1;
    end else if (pop_eof && !eof_good) begin
      frm_cnt <= frm_cnt - 1'b1;
    end
  end

  // Overflow latch: once a word of the current frame is lost, the rest of
  // that frame is swallowed until its eof, which then triggers the drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (flush || eof_bad) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end
  end

  // Registered drop pulse, one cycle per discarded frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= eof_bad;
    end
  end

endmodule

// File: tb/tb_net_pkt_fifo.sv
// Testbench for net_pkt_fifo (ADDR_WIDTH=3, AFULL_TH=5). A queue-based
// model of committed and speculative frames predicts every output; directed
// sequences add literal expectations, then randomized traffic follows.
module tb_net_pkt_fifo;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFTH  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          wr_eof = 1'b0;
  logic          wr_err = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rdata;
  logic          rd_eof;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [AW:0]   used;
  logic [AW:0]   frm_cnt;
  logic          frame_drop;

  net_pkt_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(AFTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wdata(wdata),
    .wr_eof(wr_eof), .wr_err(wr_err), .rd_en(rd_en), .rdata(rdata),
    .rd_eof(rd_eof), .empty(empty), .full(full), .almost_full(almost_full),
    .used(used), .frm_cnt(frm_cnt), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: committed words readable by DMA, speculative words of the open frame.
  logic [DW:0] cq[$];
  logic [DW:0] sq[$];
  bit          m_ovf = 1'b0;
  bit          m_drop = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int m_frames();
    int n = 0;
    foreach (cq[i]) if (cq[i][DW]) n++;
    return n;
  endfunction

  task automatic model_step(input bit f, input bit we, input logic [DW-1:0] d,
                            input bit eo, input bit er, input bit re);
    int  u = cq.size() + sq.size();
    bit  mfull = (u == DEPTH);
    logic [DW:0] tmp;
    m_drop = 1'b0;
    if (f) begin
      cq.delete();
      sq.delete();
      m_ovf = 1'b0;
    end else begin
      if (re && cq.size() > 0) tmp = cq.pop_front();
      if (we) begin
        if (eo) begin
          if (er || m_ovf || mfull) begin
            sq.delete();
            m_ovf  = 1'b0;
            m_drop = 1'b1;
          end else begin
            sq.push_back({1'b1, d});
            foreach (sq[i]) cq.push_back(sq[i]);
            sq.delete();
          end
        end else if (mfull || m_ovf) begin
          m_ovf = 1'b1;
        end else begin
          sq.push_back({1'b0, d});
        end
      end
    end
  endtask

  task automatic compare_all();
    int u = cq.size() + sq.size();
    chk("used", used, u);
    chk("full", full, (u == DEPTH));
    chk("almost_full", almost_full, (u >= AFTH));
    chk("empty", empty, (cq.size() == 0));
    chk("frm_cnt", frm_cnt, m_frames());
    chk("frame_drop", frame_drop, m_drop);
    if (cq.size() > 0) begin
      chk("rdata", rdata, cq[0][DW-1:0]);
      chk("rd_eof", rd_eof, cq[0][DW]);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic drive(input bit f, input bit we, input logic [DW-1:0] d,
                       input bit eo, input bit er, input bit re);
    flush = f; wr_en = we; wdata = d; wr_eof = eo; wr_err = er; rd_en = re;
    model_step(f, we, d, eo, er, re);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    int p_wr, p_rd;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_used", used, 0);
    chk("rst_frm", frm_cnt, 0);
    chk("rst_drop", frame_drop, 0);
    compare_all();

    // Three-word good frame, then drain it.
    drive(0, 1, 32'hA1, 0, 0, 0);
    chk("a_empty1", empty, 1);
    drive(0, 1, 32'hA2, 0, 0, 0);
    chk("a_empty2", empty, 1);
    drive(0, 1, 32'hA3, 1, 0, 0);
    chk("a_frm", frm_cnt, 1);
    chk("a_used", used, 3);
    chk("a_head", rdata, 32'hA1);
    chk("a_eof1", rd_eof, 0);
    drive(0, 0, '0, 0, 0, 1);
    chk("a_rd2", rdata, 32'hA2);
    chk("a_eof2", rd_eof, 0);
    drive(0, 0, '0, 0, 0, 1);
    chk("a_rd3", rdata, 32'hA3);
    chk("a_eof3", rd_eof, 1);
    drive(0, 0, '0, 0, 0, 1);
    chk("a_frm0", frm_cnt, 0);
    chk("a_empty_end", empty, 1);

    // Errored four-word frame is discarded.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'hE0 + i, 0, 0, 0);
      chk("e_empty", empty, 1);
    end
    drive(0, 1, 32'hE3, 1, 1, 0);
    chk("e_drop", frame_drop, 1);
    chk("e_used", used, 0);
    chk("e_empty_end", empty, 1);
    chk("e_frm", frm_cnt, 0);
    idle();
    chk("e_drop_once", frame_drop, 0);

    // Overflowing frame behind a committed one.
    drive(0, 1, 32'hB1, 0, 0, 0);
    drive(0, 1, 32'hB2, 1, 0, 0);
    for (int i = 1; i <= 6; i++) drive(0, 1, 32'hC0 + i, 0, 0, 0);
    chk("o_used8", used, 8);
    chk("o_full", full, 1);
    drive(0, 1, 32'hC7, 1, 0, 0);
    chk("o_drop", frame_drop, 1);
    chk("o_used2", used, 2);
    chk("o_frm", frm_cnt, 1);
    chk("o_head", rdata, 32'hB1);
    drive(0, 0, '0, 0, 0, 1);
    chk("o_rd2", rdata, 32'hB2);
    chk("o_eof", rd_eof, 1);
    drive(0, 0, '0, 0, 0, 1);
    chk("o_empty", empty, 1);

    // almost_full threshold on a speculative frame.
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 32'hD0 + i, 0, 0, 0);
      chk("af_level", almost_full, (i >= 5));
    end
    drive(0, 1, 32'hD6, 1, 1, 0);
    chk("af_clear", almost_full, 0);
    chk("af_used", used, 0);

    // Flush with concurrent write and read.
    drive(0, 1, 32'hF1, 1, 0, 0);
    drive(0, 1, 32'hF2, 1, 0, 0);
    drive(0, 1, 32'hF3, 0, 0, 0);
    drive(0, 1, 32'hF4, 0, 0, 0);
    drive(1, 1, 32'hF5, 0, 0, 1);
    chk("f_used", used, 0);
    chk("f_frm", frm_cnt, 0);
    chk("f_empty", empty, 1);
    chk("f_drop", frame_drop, 0);
    drive(0, 1, 32'h61, 0, 0, 0);
    drive(0, 1, 32'h62, 1, 0, 0);
    chk("f_recommit", frm_cnt, 1);
    chk("f_head", rdata, 32'h61);
    drive(0, 0, '0, 0, 0, 1);
    drive(0, 0, '0, 0, 0, 1);

    // Stream of single-word frames with continuous reads; pointers wrap.
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(0, 1, 32'h5000 + i, 1, 0, 1);
      chk("s_frm_le1", (frm_cnt <= 1), 1);
    end
    drive(0, 0, '0, 0, 0, 1);
    chk("s_drained", empty, 1);

    // Randomized traffic with varying read pressure.
    for (int i = 0; i < 3000; i++) begin
      p_wr = (i / 500) % 2 ? 80 : 55;
      p_rd = ((i / 250) % 3 == 0) ? 10 : ((i / 250) % 3 == 1 ? 50 : 90);
      drive($urandom_range(0, 99) < 1,
            $urandom_range(0, 99) < p_wr,
            $urandom,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < p_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
